stats_readout_sequencer: RTL and testbench

- Control-system-side master in front of the peripheral system's external (cs) register port.
- On a start pulse it walks the STATS_BASE select/read protocol for every cycle-count word and pushes each captured word into an output FIFO for the comm/debug host.
- When idle it passes host cs accesses straight through to the peripheral. While busy it holds them off with a grant signal.

---
 rtl/stats_readout_sequencer_pkg.sv | 35 +++
 rtl/stats_readout_sequencer_sync_fifo_fwft.sv | 73 +++++++
 rtl/stats_readout_sequencer.sv | 149 ++++++++++++++
 tb/tb_stats_readout_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stats_readout_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// stats_readout_sequencer_pkg
// Shared peripheral-side constants: cs address width, the register addresses
// the sequencer and bench care about, sequencer state encoding, and the cs bus
// bundle used to mux host and sequencer traffic.
// -----------------------------------------------------------------------------
package stats_readout_sequencer_pkg;

    // cs port byte-address width is BW_BYTE_ADDR+1 bits.
    localparam int BW_BYTE_ADDR = 7;
    localparam int CS_ADDR_W    = BW_BYTE_ADDR + 1;

    // Register map entries shared with the peripheral.
    localparam logic [CS_ADDR_W-1:0] COMM_CONTROL = 8'h04;
    localparam logic [CS_ADDR_W-1:0] STATS_BASE   = 8'h40;

    // Number of cycle-count words exposed behind STATS_BASE.
    localparam int STATS_N_WORDS = 6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_DONE = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic                 req;
        logic                 rw;
        logic [CS_ADDR_W-1:0] add;
        logic [31:0]          data;
    } cs_bus_t;

endpackage

// File: rtl/stats_readout_sequencer_sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// data_o whenever the FIFO is non-empty (zero when empty).
//   clk_i, rst_ni  clock, async active-low reset
//   flush_i        drop all contents (pointers/level to 0) next cycle
//   push_i/data_i  write request and data; accepted when not full, or when
//                  full and a pop happens the same cycle
//   pop_i          read request; ignored when empty
//   data_o         head entry
//   full_o/empty_o status
//   level_o        occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LVL);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot this cycle, so a push against a full FIFO is fine.
    assign do_push = push_i & (~full_o | do_pop);

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries no reset; data_o is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/stats_readout_sequencer.sv
// -----------------------------------------------------------------------------
// stats_readout_sequencer
// Master in front of the peripheral cs port. Idle: host cs traffic passes
// straight through. On start_i it walks the STATS_BASE select/read sequence
// for each stats word and pushes the captured words into an output FIFO.
//   clock_i, resetn_i        clock, async active-low reset
//   start_i, flush_i         begin readout / clear FIFO (both idle-only)
//   busy_o, done_o           active flag / one-cycle completion pulse
//   host_*_i, host_gnt_o     host cs port; granted only while idle
//   host_data_o              peripheral read data back to host
//   per_*_o, per_data_i      peripheral cs port
//   word_o, word_valid_o,
//   word_ready_i             FIFO head / non-empty / pop
//   fifo_level_o             FIFO occupancy
// -----------------------------------------------------------------------------
module stats_readout_sequencer
    import stats_readout_sequencer_pkg::*;
#(
    parameter int N_WORDS    = STATS_N_WORDS,
    parameter int FIFO_DEPTH = 8,
    parameter int IDX_W      = 3
) (
    input  logic                          clock_i,
    input  logic                          resetn_i,
    input  logic                          start_i,
    input  logic                          flush_i,
    output logic                          busy_o,
    output logic                          done_o,
    input  logic                          host_req_i,
    input  logic                          host_rw_i,
    input  logic [BW_BYTE_ADDR:0]         host_add_i,
    input  logic [31:0]                   host_data_i,
    output logic                          host_gnt_o,
    output logic [31:0]                   host_data_o,
    output logic                          per_req_o,
    output logic                          per_rw_o,
    output logic [BW_BYTE_ADDR:0]         per_add_o,
    output logic [31:0]                   per_data_o,
    input  logic [31:0]                   per_data_i,
    output logic [31:0]                   word_o,
    output logic                          word_valid_o,
    input  logic                          word_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    cs_bus_t          seq_bus, host_bus, per_bus;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_flush;
    logic             busy;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seq_bus   = '0;
        fifo_push = 1'b0;
        busy      = 1'b1;
        done_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start_i) begin
                    state_d = S_SEL;
                    idx_d   = '0;
                end
            end
            S_SEL: begin
                seq_bus.req  = 1'b1;
                seq_bus.rw   = 1'b1;
                seq_bus.add  = STATS_BASE;
                seq_bus.data = {{(32-IDX_W){1'b0}}, idx_q};
                state_d      = S_RD;
            end
            S_RD: begin
                seq_bus.req = 1'b1;
                seq_bus.add = STATS_BASE;
                state_d     = S_CAP;
            end
            S_CAP: begin
                // per_data_i holds its value while we wait: nothing new is read.
                if (!fifo_full || fifo_pop) begin
                    fifo_push = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SEL;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // --------------------------------------------------------- cs bus mux
    assign host_bus.req  = host_req_i;
    assign host_bus.rw   = host_rw_i;
    assign host_bus.add  = host_add_i;
    assign host_bus.data = host_data_i;

    assign per_bus    = busy ? seq_bus : host_bus;
    assign per_req_o  = per_bus.req;
    assign per_rw_o   = per_bus.rw;
    assign per_add_o  = per_bus.add;
    assign per_data_o = per_bus.data;

    assign busy_o      = busy;
    assign host_gnt_o  = ~busy;
    assign host_data_o = per_data_i;

    // --------------------------------------------------------- output FIFO
    assign fifo_pop     = word_ready_i & ~fifo_empty;
    assign fifo_flush   = flush_i & ~busy;
    assign word_valid_o = ~fifo_empty;

    sync_fifo_fwft #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock_i),
        .rst_ni  (resetn_i),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  (per_data_i),
        .pop_i   (fifo_pop),
        .data_o  (word_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

endmodule

// File: tb/tb_stats_readout_sequencer.sv
module tb_stats_readout_sequencer;
    import stats_readout_sequencer_pkg::*;

    localparam int NW    = 6;
    localparam int DEPTH = 4;
    localparam int IDX_W = 3;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    logic                 start_i = 0, flush_i = 0, busy_o, done_o;
    logic                 host_req_i = 0, host_rw_i = 0, host_gnt_o;
    logic [CS_ADDR_W-1:0] host_add_i = '0, per_add_o;
    logic [31:0]          host_data_i = '0, host_data_o;
    logic                 per_req_o, per_rw_o;
    logic [31:0]          per_data_o, per_data_i = '0, word_o;
    logic                 word_valid_o, word_ready_i = 0;
    logic [LW-1:0]        fifo_level_o;

    stats_readout_sequencer #(.N_WORDS(NW), .FIFO_DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clock_i(clock), .resetn_i(resetn), .start_i(start_i), .flush_i(flush_i),
        .busy_o(busy_o), .done_o(done_o),
        .host_req_i(host_req_i), .host_rw_i(host_rw_i), .host_add_i(host_add_i),
        .host_data_i(host_data_i), .host_gnt_o(host_gnt_o), .host_data_o(host_data_o),
        .per_req_o(per_req_o), .per_rw_o(per_rw_o), .per_add_o(per_add_o),
        .per_data_o(per_data_o), .per_data_i(per_data_i),
        .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
        .fifo_level_o(fifo_level_o)
    );

    // Peripheral: STATS_BASE write selects a word, read returns salt+select
    // one cycle later; other reads return an address-tagged pattern.
    logic [IDX_W-1:0] per_sel = '0;
    logic [31:0]      salt = 32'hA000_0000;
    always @(posedge clock) begin
        if (per_req_o && per_rw_o && per_add_o == STATS_BASE) per_sel <= per_data_o[IDX_W-1:0];
        if (per_req_o && !per_rw_o)
            per_data_i <= (per_add_o == STATS_BASE) ? salt + 32'(per_sel) : {16'hD00D, 8'h00, per_add_o};
    end

    int checks = 0, passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    // ---------------------------------------------------------------- model
    // Each accepted start appends the whole run's words; pops must come out in
    // that order. While idle every queued word must already sit in the FIFO.
    logic [31:0] expq[$];
    logic [31:0] popped[$];
    bit          busy_m = 0;
    int          done_cnt = 0;

    always @(negedge clock or negedge resetn) begin
        if (!resetn) begin
            expq.delete();
            busy_m = 0;
        end else begin
            chk1("busy", busy_o, busy_m);
            chk1("gnt", host_gnt_o, !busy_m);
            chk("host_data", host_data_o, per_data_i);
            if (!busy_m) begin
                chk1("pass_req", per_req_o, host_req_i);
                chk1("pass_rw", per_rw_o, host_rw_i);
                chk("pass_add", 32'(per_add_o), 32'(host_add_i));
                chk("pass_data", per_data_o, host_data_i);
                chk1("done_idle", done_o, 1'b0);
                chk("idle_level", 32'(fifo_level_o), 32'(expq.size()));
                chk1("idle_valid", word_valid_o, expq.size() != 0);
            end else if (per_req_o) begin
                chk("seq_add", 32'(per_add_o), 32'(STATS_BASE));
                if (per_rw_o) chk1("sel_range", per_data_o < 32'(NW), 1'b1);
            end
            if (done_o) done_cnt++;
            if (word_valid_o && word_ready_i && !(flush_i && !busy_m)) begin
                if (expq.size() == 0) chk1("pop_unexpected", word_valid_o, 1'b0);
                else begin
                    chk("pop_word", word_o, expq[0]);
                    popped.push_back(word_o);
                    void'(expq.pop_front());
                end
            end
            if (!busy_m) begin
                if (flush_i) expq.delete();
                if (start_i) begin
                    busy_m = 1;
                    for (int k = 0; k < NW; k++) expq.push_back(salt + 32'(k));
                end
            end else if (done_o) begin
                busy_m = 0;
            end
        end
    end

    // ---------------------------------------------------------------- tasks
    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic pulse_start(input logic [31:0] s);
        if (!busy_m) salt = s;
        start_i = 1;
        step();
        start_i = 0;
    endtask

    task automatic wait_done(input int max, output bit seen);
        seen = 0;
        for (int c = 0; c < max; c++) begin
            @(negedge clock);
            if (done_o) begin seen = 1; break; end
        end
        step();
    endtask

    task automatic t_full_run();
        logic [31:0] sels[$];
        int p0, done_at;
        bit seen;
        p0 = popped.size(); done_at = 0; seen = 0;
        word_ready_i = 1;
        pulse_start(32'hA000_0000);          // now in cycle t+1
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clock);
            if (per_req_o && per_rw_o && busy_o) sels.push_back(per_data_o);
            if (done_o) begin seen = 1; done_at = c; end
            step();
        end
        chk("done_latency", 32'(done_at), 32'd19);
        chk("sel_count", 32'(sels.size()), 32'd6);
        for (int k = 0; k < sels.size(); k++) chk("sel_idx", sels[k], 32'(k));
        step();
        chk("run_pops", 32'(popped.size() - p0), 32'd6);
        if (popped.size() >= p0 + 6) begin
            chk("first_word", popped[p0], 32'hA000_0000);
            chk("last_word", popped[p0+5], 32'hA000_0005);
        end
    endtask

    task automatic t_backpressure();
        int p0, d0;
        bit seen;
        p0 = popped.size(); d0 = done_cnt;
        word_ready_i = 0;
        pulse_start(32'hB000_0000);
        repeat (30) step();
        @(negedge clock);
        chk("bp_level", 32'(fifo_level_o), 32'd4);
        chk1("bp_busy", busy_o, 1'b1);
        chk("bp_no_done", 32'(done_cnt), 32'(d0));
        step();
        word_ready_i = 1;
        wait_done(60, seen);
        chk1("bp_done_seen", seen, 1'b1);
        repeat (3) step();
        chk("bp_pops", 32'(popped.size() - p0), 32'd6);
    endtask

    task automatic t_host_blocked();
        int p0, d0;
        bit found, seen;
        p0 = popped.size(); d0 = done_cnt; found = 0;
        word_ready_i = 1;
        pulse_start(32'hC000_0000);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (busy_o && per_req_o && !per_rw_o) begin found = 1; break; end
        end
        chk1("rd_found", found, 1'b1);
        #1; host_req_i = 1; host_rw_i = 0; host_add_i = COMM_CONTROL;
        #1;
        chk1("blk_gnt", host_gnt_o, 1'b0);
        chk("blk_add", 32'(per_add_o), 32'(STATS_BASE));
        chk1("blk_rw", per_rw_o, 1'b0);
        @(posedge clock); #1;
        host_req_i = 0;
        start_i = 1;                          // ignored while busy
        step();
        start_i = 0;
        wait_done(60, seen);
        chk1("blk_done_seen", seen, 1'b1);
        repeat (3) step();
        chk("blk_pops", 32'(popped.size() - p0), 32'd6);
        chk("blk_done_cnt", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic t_reset_mid();
        int p0, d0;
        bit seen, got2;
        word_ready_i = 0; got2 = 0;
        pulse_start(32'hD000_0000);
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (fifo_level_o >= LW'(2)) begin got2 = 1; break; end
        end
        chk1("rst_got2", got2, 1'b1);
        d0 = done_cnt;
        #2 resetn = 0;
        #1;
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_valid", word_valid_o, 1'b0);
        chk("rst_level", 32'(fifo_level_o), 32'd0);
        chk("rst_word", word_o, 32'd0);
        @(posedge clock); #1 resetn = 1;
        repeat (25) step();
        chk("rst_no_done", 32'(done_cnt), 32'(d0));
        p0 = popped.size();
        word_ready_i = 1;
        pulse_start(32'hE000_0000);
        wait_done(40, seen);
        chk1("rst_clean_done", seen, 1'b1);
        repeat (3) step();
        chk("rst_clean_pops", 32'(popped.size() - p0), 32'd6);
    endtask

    task automatic t_flush();
        bit seen;
        word_ready_i = 0;
        pulse_start(32'hF000_0000);
        repeat (30) step();
        word_ready_i = 1;
        repeat (3) step();                    // exactly three pops
        word_ready_i = 0;
        wait_done(40, seen);
        chk1("fl_done_seen", seen, 1'b1);
        @(negedge clock);
        chk("fl_level3", 32'(fifo_level_o), 32'd3);
        @(posedge clock); #1;
        flush_i = 1;
        step();
        flush_i = 0;
        @(negedge clock);
        chk("fl_level0", 32'(fifo_level_o), 32'd0);
        chk1("fl_valid0", word_valid_o, 1'b0);
        @(posedge clock); #1;
        pulse_start(32'hF100_0000);
        repeat (30) step();
        flush_i = 1;
        step();
        flush_i = 0;
        @(negedge clock);
        chk("fl_busy_level", 32'(fifo_level_o), 32'd4);
        @(posedge clock); #1;
        word_ready_i = 1;
        wait_done(60, seen);
        chk1("fl_busy_done", seen, 1'b1);
        repeat (3) step();
        chk("fl_busy_drain", 32'(expq.size()), 32'd0);
    endtask

    task automatic t_random();
        bit drained;
        for (int i = 0; i < 2500; i++) begin
            host_req_i   = 1'($urandom_range(0, 1));
            host_rw_i    = 1'($urandom_range(0, 1));
            host_add_i   = CS_ADDR_W'($urandom);
            host_data_i  = $urandom;
            word_ready_i = ($urandom_range(0, 3) != 0);
            flush_i      = ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 24) == 0) begin
                if (!busy_m) salt = $urandom & 32'hFFFF_FF00;
                start_i = 1;
            end else begin
                start_i = 0;
            end
            step();
        end
        start_i = 0; flush_i = 0; host_req_i = 0; word_ready_i = 1;
        drained = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (!busy_m && expq.size() == 0) begin drained = 1; break; end
        end
        chk1("rand_drained", drained, 1'b1);
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        #1;
        chk1("reset_busy", busy_o, 1'b0);
        chk1("reset_done", done_o, 1'b0);
        chk1("reset_valid", word_valid_o, 1'b0);
        chk("reset_word", word_o, 32'd0);
        chk("reset_level", 32'(fifo_level_o), 32'd0);
        chk1("reset_gnt", host_gnt_o, 1'b1);
        repeat (2) @(posedge clock);
        #1 resetn = 1;
        step();

        host_req_i = 1; host_rw_i = 1; host_add_i = COMM_CONTROL; host_data_i = 32'h0080_0000;
        #1;
        chk1("pt_req", per_req_o, 1'b1);
        chk1("pt_rw", per_rw_o, 1'b1);
        chk("pt_add", 32'(per_add_o), 32'(COMM_CONTROL));
        chk("pt_data", per_data_o, 32'h0080_0000);
        chk1("pt_gnt", host_gnt_o, 1'b1);
        step();
        host_req_i = 0; host_rw_i = 0; host_data_i = '0;
        step();

        t_full_run();
        t_backpressure();
        t_host_blocked();
        t_reset_mid();
        t_flush();
        t_random();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
